sprite_blitter: RTL and testbench

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/sprite_blitter.sv | 128 ++++++++++++
 tb/tb_sprite_blitter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a SPRITE_W x SPRITE_H sprite ROM and emits clipped,
// color-keyed framebuffer writes through a single stallable output stage.
module sprite_blitter #(
    parameter int          SPRITE_W    = 20,
    parameter int          SPRITE_H    = 20,
    parameter logic [11:0] TRANSPARENT = 12'h808,
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        flip_x,
    output logic [8:0]  rom_addr,
    input  logic [11:0] rom_color,
    output logic [9:0]  fb_x,
    output logic [9:0]  fb_y,
    output logic [11:0] fb_color,
    output logic        fb_we,
    input  logic        fb_ready,
    output logic        busy,
    output logic        done
);
    localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic [10:0] SCR_W = 11'(SCREEN_W);
    localparam logic [10:0] SCR_H = 11'(SCREEN_H);
    localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [9:0]    px, py;
    logic          flip;

    logic          stall, last_col, last_pix, pix_we;
    logic [CW-1:0] nxt_col;
    logic [RW-1:0] nxt_row;
    logic [10:0]   sx, sy;

    function automatic logic [8:0] addr_of(input logic [RW-1:0] r,
                                           input logic [CW-1:0] c,
                                           input logic f);
        return 9'(16'(r) * 16'(SPRITE_W) +
                  (f ? (16'(SPRITE_W - 1) - 16'(c)) : 16'(c)));
    endfunction

    // Sums are one bit wider than the screen so off-screen pixels clip instead of wrapping.
    always_comb begin
        stall    = fb_we & ~fb_ready;
        last_col = (col == COL_LAST);
        last_pix = last_col && (row == ROW_LAST);
        nxt_col  = last_col ? '0 : col + CW'(1);
        nxt_row  = last_col ? row + RW'(1) : row;
        sx       = {1'b0, px} + 11'(col);
        sy       = {1'b0, py} + 11'(row);
        pix_we   = (rom_color != TRANSPARENT) && (sx < SCR_W) && (sy < SCR_H);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            px       <= '0;
            py       <= '0;
            flip     <= 1'b0;
            rom_addr <= '0;
            fb_x     <= '0;
            fb_y     <= '0;
            fb_color <= '0;
            fb_we    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        px       <= pos_x;
                        py       <= pos_y;
                        flip     <= flip_x;
                        col      <= '0;
                        row      <= '0;
                        rom_addr <= addr_of('0, '0, flip_x);
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        fb_x     <= sx[9:0];
                        fb_y     <= sy[9:0];
                        fb_color <= rom_color;
                        fb_we    <= pix_we;
                        if (last_pix) begin
                            state <= DRAIN;
                        end else begin
                            col      <= nxt_col;
                            row      <= nxt_row;
                            rom_addr <= addr_of(nxt_row, nxt_col, flip);
                        end
                    end
                end
                DRAIN: begin
                    // Wait for the final pixel in the output stage to retire.
                    if (!stall) begin
                        fb_we <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        col   <= '0;
                        row   <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: expected writes queued per draw, popped on fb handshakes.
module tb_sprite_blitter;
    logic        Clk = 1'b0;
    logic        Reset, start, flip_x, fb_ready;
    logic [9:0]  pos_x, pos_y;
    logic [8:0]  rom_addr;
    logic [11:0] rom_color;
    logic [9:0]  fb_x, fb_y;
    logic [11:0] fb_color;
    logic        fb_we, busy, done;

    sprite_blitter dut (
        .Clk(Clk), .Reset(Reset), .start(start), .pos_x(pos_x), .pos_y(pos_y),
        .flip_x(flip_x), .rom_addr(rom_addr), .rom_color(rom_color),
        .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_we(fb_we),
        .fb_ready(fb_ready), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    // ROM model: constant color, or an address-dependent color that is never the key.
    logic        rom_mode;
    logic [11:0] rom_const;
    function automatic logic [11:0] rom_fn(input logic [8:0] a);
        return rom_mode ? (12'h100 + 12'(a)) : rom_const;
    endfunction
    assign rom_color = rom_fn(rom_addr);

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] sb[$];
    int cyc = 0, t_edge = 0;
    int we_cnt, wr_cnt, busy_cnt, done_cnt, first_rel, last_rel, done_rel;
    logic        prev_hold;
    logic [42:0] prev_snap;

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: one sample per cycle, well away from the rising edge.
    always @(negedge Clk) begin
        automatic int rel = cyc - t_edge + 1;
        automatic logic [42:0] snap = {fb_x, fb_y, fb_color, fb_we, rom_addr};
        if (prev_hold) chk("stall_hold", 32'(snap != prev_snap), 0);
        if (busy) begin
            busy_cnt++;
            chk("addr_max", 32'(rom_addr <= 9'd399), 1);
        end
        if (fb_we) begin
            we_cnt++;
            if (fb_ready) begin
                wr_cnt++;
                if (wr_cnt == 1) first_rel = rel;
                last_rel = rel;
                chk("clip", 32'(fb_x < 10'd640 && fb_y < 10'd480), 1);
                if (sb.size() == 0) chk("extra_wr", 1, 0);
                else chk("wr_pix", {fb_x, fb_y, fb_color}, sb.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            done_rel = rel;
            chk("done_busy", 32'(busy), 0);
        end
        prev_hold = fb_we && !fb_ready && !Reset;
        prev_snap = snap;
    end

    task automatic clr_counts();
        we_cnt = 0; wr_cnt = 0; busy_cnt = 0; done_cnt = 0;
        first_rel = -1; last_rel = -1; done_rel = -1;
    endtask

    // Queue expected writes, then pulse start; returns #1 into the first busy cycle.
    task automatic draw(input logic [9:0] x, input logic [9:0] y, input logic f);
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 20; c++) begin
                automatic logic [8:0]  a   = 9'(r * 20 + (f ? 19 - c : c));
                automatic logic [11:0] col = rom_fn(a);
                automatic int sx = int'(x) + c, sy = int'(y) + r;
                if (col != 12'h808 && sx < 640 && sy < 480)
                    sb.push_back({10'(sx), 10'(sy), col});
            end
        clr_counts();
        pos_x = x; pos_y = y; flip_x = f; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        t_edge = cyc;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_cnt == 0 && k < 1000) begin
            @(posedge Clk); #1;
            k++;
        end
        chk("done_seen", 32'(done_cnt), 1);
        @(posedge Clk); #1;
    endtask

    initial begin
        prev_hold = 1'b0; prev_snap = '0;
        clr_counts();
        Reset = 1'b1; start = 1'b0; flip_x = 1'b0; fb_ready = 1'b1;
        pos_x = '0; pos_y = '0; rom_mode = 1'b0; rom_const = 12'hE51;
        repeat (2) @(posedge Clk);
        #1 start = 1'b1;
        @(posedge Clk); #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_we", 32'(fb_we), 0);
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_fb", {fb_x, fb_y, fb_color}, 0);
        Reset = 1'b0; start = 1'b0;
        @(posedge Clk); #1;
        chk("start_in_reset", 32'(busy), 0);

        // Opaque draw
        draw(10'd100, 10'd50, 1'b0);
        chk("op_addr0", 32'(rom_addr), 0);
        wait_done();
        chk("op_writes", 32'(wr_cnt), 400);
        chk("op_first", 32'(first_rel), 2);
        chk("op_last", 32'(last_rel), 401);
        chk("op_done", 32'(done_rel), 402);
        chk("op_busy", 32'(busy_cnt), 401);
        chk("op_sb", 32'(sb.size()), 0);

        // Transparent draw
        rom_const = 12'h808;
        draw(10'd100, 10'd50, 1'b0);
        wait_done();
        chk("tr_we", 32'(we_cnt), 0);
        chk("tr_done", 32'(done_rel), 402);

        // Clipped draw
        rom_const = 12'hE51;
        draw(10'd630, 10'd470, 1'b0);
        wait_done();
        chk("clip_writes", 32'(wr_cnt), 100);
        chk("clip_we", 32'(we_cnt), 100);
        chk("clip_sb", 32'(sb.size()), 0);

        // Backpressure on the 5th write
        draw(10'd100, 10'd50, 1'b0);
        repeat (5) @(posedge Clk);
        #1 fb_ready = 1'b0;
        repeat (3) @(posedge Clk);
        #1 fb_ready = 1'b1;
        wait_done();
        chk("bp_writes", 32'(wr_cnt), 400);
        chk("bp_done", 32'(done_rel), 405);
        chk("bp_sb", 32'(sb.size()), 0);

        // Horizontal flip
        rom_mode = 1'b1;
        draw(10'd100, 10'd50, 1'b1);
        chk("flip_addr0", 32'(rom_addr), 19);
        wait_done();
        chk("flip_writes", 32'(wr_cnt), 400);
        chk("flip_sb", 32'(sb.size()), 0);

        // Abort by reset mid-draw
        rom_mode = 1'b0;
        draw(10'd100, 10'd50, 1'b0);
        repeat (99) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_we", 32'(fb_we), 0);
        sb.delete();
        clr_counts();
        repeat (30) @(posedge Clk);
        #1;
        chk("abort_no_we", 32'(we_cnt), 0);
        chk("abort_no_done", 32'(done_cnt), 0);

        // Re-arm; a start during busy (with new coordinates) must be ignored
        draw(10'd200, 10'd100, 1'b0);
        repeat (49) @(posedge Clk);
        #1 start = 1'b1; pos_x = 10'd10; pos_y = 10'd10;
        @(posedge Clk); #1 start = 1'b0;
        wait_done();
        chk("rearm_writes", 32'(wr_cnt), 400);
        chk("rearm_done", 32'(done_rel), 402);
        chk("rearm_sb", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
